// File: rtl/ib_arbiter.sv
// Two-requester, frame-atomic arbiter sharing one inputBuffer write port, with credit-based
// occupancy tracking and stall/drop flow control. Define IB_ARB_STATS_EN for traffic counters.
module ib_arbiter #(
    parameter int          N          = 8,
    parameter int          DATA_WIDTH = 32,
    parameter int          IB_DEPTH   = 4,
    parameter logic [7:0]  CFG_ID     = 8'd1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              tracing,
    input  logic [7:0]                        configId,
    input  logic [7:0]                        configData,
    input  logic [1:0]                        req_valid,
    input  logic [1:0]                        req_eof,
    input  logic [N-1:0][DATA_WIDTH-1:0]      req_vec0,
    input  logic [N-1:0][DATA_WIDTH-1:0]      req_vec1,
    output logic [1:0]                        req_ready,
    input  logic                              deq_pulse,
    output logic                              enqueue,
    output logic                              eof_out,
    output logic [N-1:0][DATA_WIDTH-1:0]      vector_out,
    output logic                              grant_id,
    output logic [$clog2(IB_DEPTH):0]         occupancy
`ifdef IB_ARB_STATS_EN
   ,output logic [15:0]                       acc_cnt0,
    output logic [15:0]                       acc_cnt1,
    output logic [15:0]                       drop_cnt
`endif
);

    localparam int                OCC_W   = $clog2(IB_DEPTH) + 1;
    localparam logic [OCC_W-1:0]  OCC_MAX = OCC_W'(IB_DEPTH - 1);
    localparam logic [OCC_W-1:0]  OCC_ONE = OCC_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARB  = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    localparam logic [1:0] MODE_P0 = 2'd1;
    localparam logic [1:0] MODE_P1 = 2'd2;

    logic [1:0]                    state_q, state_d;
    logic                          rr_ptr_q, rr_ptr_d;
    logic                          lock_id_q, lock_id_d;
    logic [1:0]                    mode_q, mode_d;
    logic                          drop_on_full_q, drop_on_full_d;
    logic [OCC_W-1:0]              occupancy_q, occupancy_d;
    logic                          enqueue_q, enqueue_d;
    logic                          eof_out_q, eof_out_d;
    logic [N-1:0][DATA_WIDTH-1:0]  vector_out_q, vector_out_d;
    logic                          grant_id_q, grant_id_d;

    logic                          first_id;
    logic                          other_id;
    logic [1:0]                    granted;
    logic                          has_room;
    logic [1:0]                    xfer_vec;
    logic                          xfer;
    logic                          src_id;
    logic                          src_eof;
    logic [N-1:0][DATA_WIDTH-1:0]  src_vec;
    logic                          dropped;
    logic                          write;
    logic                          deq_eff;
    logic                          cfg_unused;

    assign cfg_unused = |configData[7:3];

    // Arbitration order for a fresh frame; mode 3 behaves as round-robin.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        first_id = rr_ptr_q;
        case (mode_q)
            MODE_P0: first_id = 1'b0;
            MODE_P1: first_id = 1'b1;
            default: first_id = rr_ptr_q;
        endcase
        other_id = ~first_id;
    end

    always_comb begin
        granted = 2'b00;
        case (state_q)
            ST_ARB: begin
                if (tracing) begin
                    if (req_valid[first_id]) begin
                        granted[first_id] = 1'b1;
                    end else if (req_valid[other_id]) begin
                        granted[other_id] = 1'b1;
                    end
                end
            end
            ST_LOCK: granted[lock_id_q] = 1'b1;
            default: granted = 2'b00;
        endcase
    end

    // In drop mode the source is never stalled; full-buffer vectors are consumed and discarded.
    assign has_room  = drop_on_full_q | (occupancy_q < OCC_MAX);
    assign req_ready = has_room ? granted : 2'b00;

    assign xfer_vec  = req_valid & req_ready;
    assign xfer      = |xfer_vec;
    assign src_id    = xfer_vec[1];
    assign src_eof   = req_eof[src_id];
    assign src_vec   = src_id ? req_vec1 : req_vec0;
    assign dropped   = xfer & drop_on_full_q & (occupancy_q == OCC_MAX);
    assign write     = xfer & ~dropped;
    assign deq_eff   = deq_pulse & (occupancy_q != '0);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        case (state_q)
            ST_IDLE: begin
                if (tracing) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (!tracing) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    if (src_eof) begin
                        rr_ptr_d = ~src_id;
                    end else begin
                        state_d   = ST_LOCK;
                        lock_id_d = src_id;
                    end
                end
            end
            ST_LOCK: begin
                // A frame in flight always completes, even after tracing drops.
                if (xfer && src_eof) begin
                    rr_ptr_d = ~src_id;
                    state_d  = tracing ? ST_ARB : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        occupancy_d = occupancy_q;
        case ({write, deq_eff})
            2'b10:   occupancy_d = occupancy_q + OCC_ONE;
            2'b01:   occupancy_d = occupancy_q - OCC_ONE;
            default: occupancy_d = occupancy_q;
        endcase
    end

    always_comb begin
        enqueue_d    = write;
        eof_out_d    = write & src_eof;
        vector_out_d = write ? src_vec : vector_out_q;
        grant_id_d   = write ? src_id  : grant_id_q;
    end

    always_comb begin
        mode_d         = mode_q;
        drop_on_full_d = drop_on_full_q;
        if (configId == CFG_ID) begin
            mode_d         = configData[1:0];
            drop_on_full_d = configData[2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= 1'b0;
            lock_id_q      <= 1'b0;
            mode_q         <= 2'd0;
            drop_on_full_q <= 1'b0;
            occupancy_q    <= '0;
            enqueue_q      <= 1'b0;
            eof_out_q      <= 1'b0;
            vector_out_q   <= '0;
            grant_id_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            lock_id_q      <= lock_id_d;
            mode_q         <= mode_d;
            drop_on_full_q <= drop_on_full_d;
            occupancy_q    <= occupancy_d;
            enqueue_q      <= enqueue_d;
            eof_out_q      <= eof_out_d;
            vector_out_q   <= vector_out_d;
            grant_id_q     <= grant_id_d;
        end
    end

    assign enqueue    = enqueue_q;
    assign eof_out    = eof_out_q;
    assign vector_out = vector_out_q;
    assign grant_id   = grant_id_q;
    assign occupancy  = occupancy_q;

`ifdef IB_ARB_STATS_EN
    localparam logic [15:0] CNT_MAX = 16'hFFFF;
    localparam logic [15:0] CNT_ONE = 16'd1;

    logic [15:0] acc_cnt0_q, acc_cnt0_d;
    logic [15:0] acc_cnt1_q, acc_cnt1_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating counters: they stick at all-ones instead of wrapping.
    always_comb begin
        acc_cnt0_d = acc_cnt0_q;
        acc_cnt1_d = acc_cnt1_q;
        drop_cnt_d = drop_cnt_q;
        if (write && !src_id && acc_cnt0_q != CNT_MAX) begin
            acc_cnt0_d = acc_cnt0_q + CNT_ONE;
        end
        if (write && src_id && acc_cnt1_q != CNT_MAX) begin
            acc_cnt1_d = acc_cnt1_q + CNT_ONE;
        end
        if (dropped && drop_cnt_q != CNT_MAX) begin
            drop_cnt_d = drop_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_cnt0_q <= '0;
            acc_cnt1_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            acc_cnt0_q <= acc_cnt0_d;
            acc_cnt1_q <= acc_cnt1_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign acc_cnt0 = acc_cnt0_q;
    assign acc_cnt1 = acc_cnt1_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule
